// File: rtl/seg_scan_counter.sv
// seg_scan_counter
//   Multi-digit BCD up/down event counter with a scanned (time-multiplexed)
//   7-segment display driver.
//
//   The count updates on single-cycle inc/dec pulses with decimal carry and
//   borrow. At the limits it either wraps, pulsing `wrap` for one cycle, or
//   saturates, as chosen by `sat_mode`. A free-running divider steps the
//   display through the digits, holding each one for SCAN_DIV cycles.
//
//   Handshake: there is none. inc/dec/clr are plain level-sampled strobes.
//   Every cycle one of them is high is acted on, so back-to-back pulses each
//   count.
//
// Parameters
//   DIGITS         number of BCD digits / select lines (1..8)
//   SCAN_DIV       clk cycles each digit is driven (>= 2)
//   SEG_ACTIVE_LOW 1 = segment/select outputs active-low
//   BLANK_LEADING  1 = blank leading zero digits (digit 0 never blanked)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   inc       count-up pulse
//   dec       count-down pulse
//   clr       synchronous clear of the count
//   sat_mode  0 = wrap at limits, 1 = saturate at limits
//   count     registered BCD value, digit i in bits [4i+3:4i]
//   wrap      one-cycle pulse on wrap-around
//   segment   bit0..6 = a..g, bit7 = dp
//   select    one-hot digit enable, bit i drives digit i
module seg_scan_counter #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  input  logic                clr,
  input  logic                sat_mode,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic [7:0]          segment,
  output logic [DIGITS-1:0]   select
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  // Output polarity masks: XOR-ing with these converts active-high to the
  // configured polarity.
  localparam logic [7:0]        SEG_POL = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_POL = {DIGITS{SEG_ACTIVE_LOW}};

  // Active-high glyph table, dp (bit 7) always off.
  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'h3F;
      4'd1:    decode = 8'h06;
      4'd2:    decode = 8'h5B;
      4'd3:    decode = 8'h4F;
      4'd4:    decode = 8'h66;
      4'd5:    decode = 8'h6D;
      4'd6:    decode = 8'h7D;
      4'd7:    decode = 8'h07;
      4'd8:    decode = 8'h7F;
      4'd9:    decode = 8'h6F;
      default: decode = 8'h00;
    endcase
  endfunction

  // --------------------------------------------------------------------
  // BCD increment / decrement
  // The carry (borrow) ripples upward only while the lower digits are all
  // 9 (0). So a carry still pending after the top digit means the count
  // was all-9s (all-0s).
  // --------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] count_dec;
  logic                carry;
  logic                borrow;

  always_comb begin
    count_inc = count;
    count_dec = count;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Priority: rst > clr > (inc & dec cancel) > inc > dec.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (inc && !dec) begin
        if (!carry) begin
          count <= count_inc;
        end else if (!sat_mode) begin
          count <= '0;
          wrap  <= 1'b1;
        end
      end else if (dec && !inc) begin
        if (!borrow) begin
          count <= count_dec;
        end else if (!sat_mode) begin
          count <= ALL_NINES;
          wrap  <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------
  // Scan divider and digit index
  // --------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;

  always_comb begin
    idx_nxt = idx_q;
    if (div_q == DIV_LAST) begin
      idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      idx_q <= idx_nxt;
    end
  end

  // --------------------------------------------------------------------
  // Leading-zero blanking
  // Walking down from the top digit, a digit is blanked while everything
  // at and above it is zero. Digit 0 is never blanked.
  // --------------------------------------------------------------------
  logic [3:0]        digit_val [DIGITS];
  logic [DIGITS-1:0] blank;
  logic              upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit_val[i] = count[4*i +: 4];
      upper_zero   = upper_zero && (count[4*i +: 4] == 4'd0);
      if (BLANK_LEADING && (i > 0)) begin
        blank[i] = upper_zero;
      end
    end
  end

  // --------------------------------------------------------------------
  // Display stage
  // The display registers are fed by the index value being loaded on this
  // same edge (idx_nxt). This lets select/segment switch together with
  // the index instead of one cycle behind it, so every digit gets exactly
  // SCAN_DIV cycles.
  // --------------------------------------------------------------------
  logic [7:0]        glyph;
  logic [DIGITS-1:0] sel_onehot;

  always_comb begin
    glyph      = blank[idx_nxt] ? 8'h00 : decode(digit_val[idx_nxt]);
    sel_onehot = DIGITS'(1) << idx_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      select  <= DIGITS'(1) ^ SEL_POL;
      segment <= decode(4'd0) ^ SEG_POL;
    end else begin
      select  <= sel_onehot ^ SEL_POL;
      segment <= glyph ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_seg_scan_counter.sv
// Testbench for seg_scan_counter with DIGITS=4, SCAN_DIV=4, active-low
// outputs and leading-zero blanking. The reference model holds the count
// as a plain decimal integer. It derives the display from the cycle count
// since reset and from decimal digit arithmetic.
module tb_seg_scan_counter;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        clr = 1'b0;
  logic        sat_mode = 1'b0;
  logic [15:0] count;
  logic        wrap;
  logic [7:0]  segment;
  logic [3:0]  select;

  seg_scan_counter #(
    .DIGITS        (DIGITS),
    .SCAN_DIV      (SCAN_DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .dec     (dec),
    .clr     (clr),
    .sat_mode(sat_mode),
    .count   (count),
    .wrap    (wrap),
    .segment (segment),
    .select  (select)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int   m_count = 0;  // decimal value 0..9999
  int   m_prev  = 0;  // value the display stage sampled on the last edge
  int   m_ticks = 0;  // edges since the reset edge
  logic m_wrap  = 1'b0;

  logic [7:0] glyph_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [7:0] frame_1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] frame_0007 [4] = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] frame_0100 [4] = '{8'hC0, 8'hC0, 8'hF9, 8'hFF};

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return b;
  endfunction

  function automatic int exp_slot();
    return (m_ticks / SCAN_DIV) % DIGITS;
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int slot);
    logic [7:0] g;
    g = glyph_tab[(v / pow10(slot)) % 10];
    if (slot > 0 && v < pow10(slot)) g = 8'h00;
    return ~g;
  endfunction

  function automatic logic [3:0] exp_sel(input int slot);
    return ~(4'b0001 << slot);
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances the model across the edge, then
  // leaves the bench 1 time unit past the edge for sampling.
  task automatic step(input logic i_inc, input logic i_dec,
                      input logic i_clr, input logic i_rst);
    inc = i_inc; dec = i_dec; clr = i_clr; rst = i_rst;
    @(posedge clk);
    if (i_rst) begin
      m_count = 0; m_prev = 0; m_ticks = 0; m_wrap = 1'b0;
    end else begin
      m_prev  = m_count;
      m_ticks = m_ticks + 1;
      m_wrap  = 1'b0;
      if (i_clr) begin
        m_count = 0;
      end else if (i_inc && !i_dec) begin
        if (m_count < 9999) m_count = m_count + 1;
        else if (!sat_mode) begin m_count = 0; m_wrap = 1'b1; end
      end else if (i_dec && !i_inc) begin
        if (m_count > 0) m_count = m_count - 1;
        else if (!sat_mode) begin m_count = 9999; m_wrap = 1'b1; end
      end
    end
    #1;
    inc = 1'b0; dec = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", count); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    n_checks++; if (select !== 4'b1110) begin n_fail++; $display("FAIL reset_select: got %b expected 1110", select); end
    n_checks++; if (segment !== 8'hC0) begin n_fail++; $display("FAIL reset_segment: got %h expected c0", segment); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (select !== 4'b1110) begin n_fail++; $display("FAIL reset_slot0_hold: got %b expected 1110", select); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (select !== 4'b1101) begin n_fail++; $display("FAIL reset_slot1_select: got %b expected 1101", select); end
    n_checks++; if (segment !== 8'hFF) begin n_fail++; $display("FAIL reset_slot1_blank: got %h expected ff", segment); end
  endtask

  task automatic test_carry_chain();
    sat_mode = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1234; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h1234) begin n_fail++; $display("FAIL carry_count: got %h expected 1234", count); end
    for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (segment !== frame_1234[exp_slot()]) begin n_fail++; $display("FAIL carry_segment slot %0d: got %h expected %h", exp_slot(), segment, frame_1234[exp_slot()]); end
      n_checks++; if (select !== exp_sel(exp_slot())) begin n_fail++; $display("FAIL carry_select: got %b expected %b", select, exp_sel(exp_slot())); end
    end
  endtask

  task automatic test_wrap();
    sat_mode = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h9999) begin n_fail++; $display("FAIL wrap_dec_count: got %h expected 9999", count); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_dec_pulse: got %b expected 1", wrap); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_width: got %b expected 0", wrap); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL wrap_inc_count: got %h expected 0000", count); end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_inc_pulse: got %b expected 1", wrap); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_inc_clear: got %b expected 0", wrap); end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    sat_mode = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL sat_dec_count: got %h expected 0000", count); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL sat_dec_wrap: got %b expected 0", wrap); end
    sat_mode = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    sat_mode = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h9999) begin n_fail++; $display("FAIL sat_inc_count: got %h expected 9999", count); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL sat_inc_wrap: got %b expected 0", wrap); end
    sat_mode = 1'b0;
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h0050) begin n_fail++; $display("FAIL simul_incdec: got %h expected 0050", count); end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL simul_clrinc: got %h expected 0000", count); end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL simul_rst_count: got %h expected 0000", count); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL simul_rst_wrap: got %b expected 0", wrap); end
    n_checks++; if (select !== 4'b1110) begin n_fail++; $display("FAIL simul_rst_select: got %b expected 1110", select); end
    n_checks++; if (segment !== 8'hC0) begin n_fail++; $display("FAIL simul_rst_segment: got %h expected c0", segment); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (select !== 4'b1110) begin n_fail++; $display("FAIL simul_rst_slot0: got %b expected 1110", select); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (select !== 4'b1101) begin n_fail++; $display("FAIL simul_rst_slot1: got %b expected 1101", select); end
  endtask

  task automatic test_blanking();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (segment !== frame_0007[exp_slot()]) begin n_fail++; $display("FAIL blank7_segment slot %0d: got %h expected %h", exp_slot(), segment, frame_0007[exp_slot()]); end
      n_checks++; if (select !== exp_sel(exp_slot())) begin n_fail++; $display("FAIL blank7_select: got %b expected %b", select, exp_sel(exp_slot())); end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (count !== 16'h0100) begin n_fail++; $display("FAIL blank100_count: got %h expected 0100", count); end
    for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (segment !== frame_0100[exp_slot()]) begin n_fail++; $display("FAIL blank100_segment slot %0d: got %h expected %h", exp_slot(), segment, frame_0100[exp_slot()]); end
    end
  endtask

  task automatic test_random();
    int r;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    sat_mode = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);  // start at 9999 so wraps occur early
    for (int k = 0; k < 1500; k++) begin
      sat_mode = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 15);
      step(r < 6, (r >= 5) && (r < 12), r == 15, $urandom_range(0, 299) == 0);
      n_checks++; if (count !== to_bcd(m_count)) begin n_fail++; $display("FAIL rand_count cyc %0d: got %h expected %h", k, count, to_bcd(m_count)); end
      n_checks++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL rand_wrap cyc %0d: got %b expected %b", k, wrap, m_wrap); end
      n_checks++; if (select !== exp_sel(exp_slot())) begin n_fail++; $display("FAIL rand_select cyc %0d: got %b expected %b", k, select, exp_sel(exp_slot())); end
      n_checks++; if (segment !== exp_seg(m_prev, exp_slot())) begin n_fail++; $display("FAIL rand_segment cyc %0d: got %h expected %h", k, segment, exp_seg(m_prev, exp_slot())); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_carry_chain();
    test_wrap();
    test_saturate();
    test_simultaneous();
    test_blanking();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
